// File: rtl/prod_obs_align.sv
// ---------------------------------------------------------------------------
// prod_obs_align
// Consumer of the Left/Right self-composed rv32_5stage tile IO in the product
// harness. Each copy's data-memory requests (master_port_1 req) go into a
// small FIFO per side. When both FIFOs hold an entry, the two heads are popped
// together and compared. A copy that runs ahead fills its FIFO. Its stall
// output then asks the harness to stutter that copy until the other catches up.
//
// Ports
//   clock, reset            sole clock; asynchronous active-high reset
//   l_req_* / r_req_*       valid, addr, data, fcn (1 = write), typ per copy
//   l_stall / r_stall       side FIFO is full
//   src_cand_equiv          1 while no divergence has been seen
//   mismatch                sticky: a compared pair differed
//   overflow                sticky: a push into a full FIFO was dropped
//   l_count / r_count       FIFO occupancy
//
// Optional feature (macro PROD_OBS_TRACE_EN)
//   Adds fail_index, fail_l_addr and fail_r_addr. They capture the failing pair
//   when a mismatch moves the checker into FAIL.
// ---------------------------------------------------------------------------
module prod_obs_align #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     l_req_valid,
    input  logic [ADDR_W-1:0]        l_req_addr,
    input  logic [DATA_W-1:0]        l_req_data,
    input  logic                     l_req_fcn,
    input  logic [2:0]               l_req_typ,
    input  logic                     r_req_valid,
    input  logic [ADDR_W-1:0]        r_req_addr,
    input  logic [DATA_W-1:0]        r_req_data,
    input  logic                     r_req_fcn,
    input  logic [2:0]               r_req_typ,
    output logic                     l_stall,
    output logic                     r_stall,
    output logic                     src_cand_equiv,
    output logic                     mismatch,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   l_count,
    output logic [$clog2(DEPTH):0]   r_count
`ifdef PROD_OBS_TRACE_EN
    ,
    output logic [31:0]              fail_index,
    output logic [ADDR_W-1:0]        fail_l_addr,
    output logic [ADDR_W-1:0]        fail_r_addr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Entry layout: {addr, data, fcn, typ}
    localparam int EW = ADDR_W + DATA_W + 4;

    typedef enum logic [0:0] {CHECK = 1'b0, FAIL = 1'b1} state_t;

    // Compares two entries. The data field matters only for writes.
    function automatic logic pairDiffers(input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic d;
        d = (a[EW-1 -: ADDR_W] != b[EW-1 -: ADDR_W]) | (a[3] != b[3]) | (a[2:0] != b[2:0]);
        if (a[3]) begin
            d = d | (a[DATA_W+3:4] != b[DATA_W+3:4]);
        end else begin
            d = d;
        end
        return d;
    endfunction

    logic [EW-1:0] lMem_r [DEPTH];
    logic [EW-1:0] rMem_r [DEPTH];
    logic [AW-1:0] lWr_r, lRd_r, rWr_r, rRd_r;
    logic [CW-1:0] lCount_r, rCount_r, lCountNext_s, rCountNext_s;
    logic          mismatch_r, overflow_r, equiv_r, lStall_r, rStall_r;
    logic          mismatchNext_s, overflowNext_s, newMismatch_s, newOverflow_s;
    logic          pop_s, lPush_s, rPush_s, lFull_s, rFull_s, diff_s;
    logic [EW-1:0] lHead_s, rHead_s;
    state_t        state_r, stateNext_s;

    // Pop/push arbitration, compare, flag updates and next state.
    always_comb begin
        lHead_s        = lMem_r[lRd_r];
        rHead_s        = rMem_r[rRd_r];
        lFull_s        = (lCount_r == CW'(DEPTH));
        rFull_s        = (rCount_r == CW'(DEPTH));
        pop_s          = (state_r == CHECK) && (lCount_r != {CW{1'b0}}) && (rCount_r != {CW{1'b0}});
        // A full side still accepts a push when its head leaves in the same cycle.
        lPush_s        = l_req_valid && (!lFull_s || pop_s);
        rPush_s        = r_req_valid && (!rFull_s || pop_s);
        diff_s         = pop_s && pairDiffers(lHead_s, rHead_s);
        // Flags are frozen once in FAIL.
        newMismatch_s  = (state_r == CHECK) && diff_s;
        newOverflow_s  = (state_r == CHECK) && ((l_req_valid && !lPush_s) || (r_req_valid && !rPush_s));
        mismatchNext_s = mismatch_r | newMismatch_s;
        overflowNext_s = overflow_r | newOverflow_s;
        lCountNext_s   = lCount_r + {{(CW-1){1'b0}}, lPush_s} - {{(CW-1){1'b0}}, pop_s};
        rCountNext_s   = rCount_r + {{(CW-1){1'b0}}, rPush_s} - {{(CW-1){1'b0}}, pop_s};
        stateNext_s    = state_r;
        case (state_r)
            CHECK: begin
                if (newMismatch_s || newOverflow_s) begin
                    stateNext_s = FAIL;
                end else begin
                    stateNext_s = CHECK;
                end
            end
            FAIL:    stateNext_s = FAIL;
            default: stateNext_s = FAIL;
        endcase
    end

    // Control state: pointers, counts, sticky flags, stalls and FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lWr_r      <= {AW{1'b0}};
            lRd_r      <= {AW{1'b0}};
            rWr_r      <= {AW{1'b0}};
            rRd_r      <= {AW{1'b0}};
            lCount_r   <= {CW{1'b0}};
            rCount_r   <= {CW{1'b0}};
            mismatch_r <= 1'b0;
            overflow_r <= 1'b0;
            equiv_r    <= 1'b1;
            lStall_r   <= 1'b0;
            rStall_r   <= 1'b0;
            state_r    <= CHECK;
        end else begin
            lWr_r      <= lPush_s ? lWr_r + AW'(1'b1) : lWr_r;
            rWr_r      <= rPush_s ? rWr_r + AW'(1'b1) : rWr_r;
            lRd_r      <= pop_s ? lRd_r + AW'(1'b1) : lRd_r;
            rRd_r      <= pop_s ? rRd_r + AW'(1'b1) : rRd_r;
            lCount_r   <= lCountNext_s;
            rCount_r   <= rCountNext_s;
            mismatch_r <= mismatchNext_s;
            overflow_r <= overflowNext_s;
            equiv_r    <= !(mismatchNext_s | overflowNext_s);
            lStall_r   <= (lCountNext_s == CW'(DEPTH));
            rStall_r   <= (rCountNext_s == CW'(DEPTH));
            state_r    <= stateNext_s;
        end
    end

    // FIFO storage. Entries beyond the pointers are don't-care, so no reset is needed.
    always_ff @(posedge clock) begin
        if (lPush_s) begin
            lMem_r[lWr_r] <= {l_req_addr, l_req_data, l_req_fcn, l_req_typ};
        end
        if (rPush_s) begin
            rMem_r[rWr_r] <= {r_req_addr, r_req_data, r_req_fcn, r_req_typ};
        end
    end

    assign l_stall        = lStall_r;
    assign r_stall        = rStall_r;
    assign src_cand_equiv = equiv_r;
    assign mismatch       = mismatch_r;
    assign overflow       = overflow_r;
    assign l_count        = lCount_r;
    assign r_count        = rCount_r;

`ifdef PROD_OBS_TRACE_EN
    logic [31:0]       pairCount_r, failIndex_r;
    logic [ADDR_W-1:0] failLAddr_r, failRAddr_r;

    // Counts compared pairs and snapshots the first mismatching pair.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pairCount_r <= 32'd0;
            failIndex_r <= 32'd0;
            failLAddr_r <= {ADDR_W{1'b0}};
            failRAddr_r <= {ADDR_W{1'b0}};
        end else begin
            if (pop_s) begin
                pairCount_r <= pairCount_r + 32'd1;
            end
            if (newMismatch_s) begin
                failIndex_r <= pairCount_r;
                failLAddr_r <= lHead_s[EW-1 -: ADDR_W];
                failRAddr_r <= rHead_s[EW-1 -: ADDR_W];
            end
        end
    end

    assign fail_index  = failIndex_r;
    assign fail_l_addr = failLAddr_r;
    assign fail_r_addr = failRAddr_r;
`endif

endmodule
